// File: rtl/common_dffram_fifo.sv
// ---------------------------------------------------------------------------
// common_dffram_fifo
//
// Single-clock first-word-fall-through FIFO built on flip-flop storage.
// The storage array has one write port with a per-bit write enable and one
// combinational read port. The FIFO controller owns both storage ports.
//
// Optional feature macro: COMMON_DFFRAM_FIFO_BYPASS_EN
//   defined   : an empty FIFO forwards s_data straight to m_data while
//               s_valid=1. If the consumer takes it that cycle, nothing is
//               stored.
//   undefined : no combinational path from s_* to m_*. Minimum latency is
//               one cycle.
//
// Parameters
//   FIFO_DATA_WIDTH : entry width in bits
//   FIFO_ADDR_WIDTH : log2 of depth (>= 1)
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   flush   : synchronous clear of all entries, beats push/pop
//   s_valid : producer has data
//   s_ready : FIFO can accept (== !full)
//   s_data  : producer data
//   m_valid : head entry available
//   m_ready : consumer takes the head entry
//   m_data  : head entry data
//   count   : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------

// Flip-flop storage: one write port with a bit mask, one combinational read port.
module common_dffram_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (|wen) begin
      mem[waddr] <= (mem[waddr] & ~wen) | (wdata & wen);
    end
  end

  assign rdata = mem[raddr];

endmodule

module common_dffram_fifo #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  output logic [FIFO_ADDR_WIDTH:0]   count
);

  localparam logic [FIFO_ADDR_WIDTH:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy register.
  logic [FIFO_ADDR_WIDTH:0]   wptr;
  logic [FIFO_ADDR_WIDTH:0]   rptr;
  logic                       empty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       bypass_take;

  logic [FIFO_ADDR_WIDTH-1:0] mem_waddr;
  logic [FIFO_DATA_WIDTH-1:0] mem_wen;
  logic [FIFO_DATA_WIDTH-1:0] mem_wdata;
  logic [FIFO_ADDR_WIDTH-1:0] mem_raddr;
  logic [FIFO_DATA_WIDTH-1:0] mem_rdata;

  // Status from registers only; s_ready never looks at m_ready.
  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_ADDR_WIDTH-1:0] == rptr[FIFO_ADDR_WIDTH-1:0]) &&
                 (wptr[FIFO_ADDR_WIDTH] != rptr[FIFO_ADDR_WIDTH]);
  assign count = wptr - rptr;

  assign s_ready = ~full;

`ifdef COMMON_DFFRAM_FIFO_BYPASS_EN
  logic bypass;

  // Forwarding only happens into an empty queue. Reset is included so that the
  // outputs hold their reset values even with s_valid high.
  assign bypass      = empty & s_valid & ~flush & ~reset;
  assign bypass_take = bypass & m_ready;
  assign m_valid     = ~empty | bypass;
  assign m_data      = bypass ? s_data : mem_rdata;
`else
  assign bypass_take = 1'b0;
  assign m_valid     = ~empty;
  assign m_data      = mem_rdata;
`endif

  // A bypassed entry is consumed without touching storage or pointers.
  assign push = s_valid & s_ready & ~flush & ~bypass_take;
  assign pop  = ~empty & m_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  assign mem_waddr = wptr[FIFO_ADDR_WIDTH-1:0];
  assign mem_wen   = {FIFO_DATA_WIDTH{push}};
  assign mem_wdata = s_data;
  assign mem_raddr = rptr[FIFO_ADDR_WIDTH-1:0];

  common_dffram_fifo_mem #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .waddr (mem_waddr),
    .wen   (mem_wen),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule
